adc_sync_fifo: RTL and testbench
================================

Name: adc_sync_fifo

Overview:
Single-clock parametrised FIFO for buffering ADC/DAC sample streams between acquisition logic and downstream processing. It adds several things to the team's basic sample FIFO: guarded read/write accept, a true full count of DEPTH, runtime-programmable almost thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.

Parameters:
DATA_W, 14, sample word width in bits.
DEPTH, 64, number of storage words; must be a power of two and at least 4.
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
CW, $clog2(DEPTH)+1, count/threshold width (derived; do not override).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous clear of contents, pointers and count.
clr_err  in  1  synchronous clear of the sticky error flags.
wr_en  in  1  write request.
wr_data  in  DATA_W  write word.
rd_en  in  1  read request (pop in FWFT mode).
rd_data  out  DATA_W  read word.
rd_valid  out  1  rd_data holds a valid word.
almst_full_th  in  CW  almost-full level.
almst_empty_th  in  CW  almost-empty level.
fifo_count  out  CW  stored words, 0..DEPTH.
fifo_full  out  1  count == DEPTH.
fifo_empty  out  1  count == 0.
fifo_almst_full  out  1  count >= almst_full_th.
fifo_almst_empty  out  1  count <= almst_empty_th.
fifo_above_half  out  1  count > DEPTH/2.
overflow  out  1  sticky: write attempted while full.
underflow  out  1  sticky: read attempted with nothing to read.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Pointers, fifo_count, rd_data and rd_valid go to 0; overflow and underflow go to 0.
  - Flags then follow the count: empty=1, full=0, almst_empty=1, above_half=0.
  - RAM contents are not reset.
- Flags are combinational from fifo_count and the threshold ports.
- Accept rules:
  - wr_acc = wr_en & !fifo_full.
  - Standard mode: rd_acc = rd_en & !fifo_empty.
  - FWFT mode: rd_acc = rd_en & rd_valid.
  - A rejected write drops the data; a rejected read leaves rd_data unchanged.
- Count:
  - wr_acc only: +1. rd_acc only: -1. Both or neither: unchanged.
  - Count never exceeds DEPTH and never goes below 0.
- Pointers advance only on accept and wrap from DEPTH-1 to 0.
- Full boundary: when full with wr_en=1 and rd_en=1, the read is accepted, the write is rejected, overflow is set, and the count becomes DEPTH-1.
- Empty boundary: when empty with wr_en=1 and rd_en=1, the write is accepted, the read is rejected, underflow is set, and the count becomes 1.
- Error flags:
  - overflow is set on wr_en & fifo_full; underflow is set on rd_en with no accept.
  - Both hold until clr_err or reset. If a set condition and clr_err occur in the same cycle, set wins.
- Standard read (FWFT=0):
  - On an rd_acc at edge N, rd_data = head word after edge N, and rd_valid=1 for that one cycle.
  - rd_data otherwise holds its value; rd_valid=0 otherwise.
- FWFT read (FWFT=1):
  - Whenever a word is present in the output stage, rd_valid=1 and rd_data shows the head word.
  - A word written into an empty FIFO at edge N appears with rd_valid=1 after edge N+1.
  - rd_acc pops the word. If more words are stored, the next word is shown after the same edge (back-to-back, no bubble).
  - fifo_count includes the word held in the output stage.
- flush:
  - Priority over wr_en and rd_en in the same cycle.
  - After the edge: count=0, pointers=0, rd_valid=0.
  - rd_data and the error flags are kept.
- Threshold ports may change at any time; the flags track them combinationally.

Test Plan:
- Reset, then write 0x0001..0x0040 (64 words) with DEPTH=64 -> count=64, full=1, above_half=1, overflow=0. A 65th write sets overflow=1, count stays 64, and data is not stored.
- Standard mode: read 64 words -> rd_data sequence 0x0001..0x0040, each 1 cycle after rd_en, with rd_valid pulsed. A 65th rd_en sets underflow=1 and rd_data stays 0x0040.
- Full plus simultaneous wr_en/rd_en with wr_data=0x3FFF -> read accepted, write rejected, count=63, overflow=1. Then clr_err -> both flags 0.
- Empty plus simultaneous wr_en(0x0AAA)/rd_en -> count=1, underflow=1. A next-cycle read returns 0x0AAA.
- FWFT=1: write 0x0123 at edge N -> rd_valid=1 with rd_data=0x0123 after edge N+1. Then write 0x0456 and pop on successive cycles -> 0x0456 is shown the cycle after the first pop, with no bubble.
- Wrap-around and thresholds: with almst_full_th=60 and almst_empty_th=4, run 200 interleaved writes and reads at random rates (incrementing data). Check the data stays in order across pointer wrap and almst_full/almst_empty toggle at counts 60 and 4. A flush mid-stream gives count=0 and empty=1 after one edge. rst_n asserted mid-burst clears everything immediately.

Source files
------------

// File: rtl/adc_sync_fifo.sv
// Single-clock sample FIFO with guarded accept, programmable almost thresholds,
// sticky error flags, synchronous flush and optional first-word-fall-through read.
module adc_sync_fifo #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 64,
    parameter bit FWFT   = 1'b0,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              clr_err,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic [CW-1:0]     almst_full_th,
    input  logic [CW-1:0]     almst_empty_th,
    output logic [CW-1:0]     fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_almst_full,
    output logic              fifo_almst_empty,
    output logic              fifo_above_half,
    output logic              overflow,
    output logic              underflow
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]  HALF_C  = CW'(DEPTH / 2);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              wr_acc, rd_acc, load;
    logic              ovf_set, udf_set;
    logic [CW-1:0]     ram_cnt;

    assign fifo_count       = count_q;
    assign fifo_full        = (count_q == DEPTH_C);
    assign fifo_empty       = (count_q == '0);
    assign fifo_almst_full  = (count_q >= almst_full_th);
    assign fifo_almst_empty = (count_q <= almst_empty_th);
    assign fifo_above_half  = (count_q > HALF_C);
    assign rd_data          = rd_data_q;
    assign rd_valid         = rd_valid_q;
    assign overflow         = overflow_q;
    assign underflow        = underflow_q;

    // In FWFT mode the output stage holds one counted word, so the RAM only
    // owns count minus the presented word; that remainder drives the prefetch.
    always_comb begin
        wr_acc  = wr_en & ~fifo_full & ~flush;
        ram_cnt = count_q;
        if (FWFT) begin
            rd_acc  = rd_en & rd_valid_q & ~flush;
            ram_cnt = count_q - {{(CW-1){1'b0}}, rd_valid_q};
            load    = (ram_cnt != '0) & (~rd_valid_q | rd_acc) & ~flush;
        end else begin
            rd_acc  = rd_en & ~fifo_empty & ~flush;
            load    = rd_acc;
        end
        ovf_set = wr_en & fifo_full & ~flush;
        udf_set = rd_en & ~rd_acc & ~flush;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        overflow_d  = ovf_set | (overflow_q & ~clr_err);
        underflow_d = udf_set | (underflow_q & ~clr_err);

        if (wr_acc)
            wr_ptr_d = wr_ptr_q + PTR_ONE;

        if (load) begin
            rd_data_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
        end

        if (FWFT)
            rd_valid_d = load | (rd_valid_q & ~rd_acc);
        else
            rd_valid_d = rd_acc;

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Flush drops contents but leaves the last read word and error history.
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_adc_sync_fifo.sv
// Scoreboard bench: a standard-mode DEPTH=64 instance checked cycle by cycle
// against a queue model, plus a small FWFT instance with directed sequences.
module tb_adc_sync_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // standard-mode instance
    logic        flush = 0, clr_err = 0, wr_en = 0, rd_en = 0;
    logic [13:0] wr_data = '0;
    logic [13:0] rd_data;
    logic        rd_valid;
    logic [6:0]  af_th = 7'd60, ae_th = 7'd4;
    logic [6:0]  fifo_count;
    logic        fifo_full, fifo_empty, fifo_almst_full, fifo_almst_empty, fifo_above_half;
    logic        overflow, underflow;

    adc_sync_fifo #(.DATA_W(14), .DEPTH(64), .FWFT(1'b0)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .almst_full_th(af_th), .almst_empty_th(ae_th),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_almst_full(fifo_almst_full), .fifo_almst_empty(fifo_almst_empty),
        .fifo_above_half(fifo_above_half), .overflow(overflow), .underflow(underflow)
    );

    // FWFT instance
    logic        f_flush = 0, f_clr_err = 0, f_wr_en = 0, f_rd_en = 0;
    logic [13:0] f_wr_data = '0;
    logic [13:0] f_rd_data;
    logic        f_rd_valid;
    logic [3:0]  f_af_th = 4'd6, f_ae_th = 4'd1;
    logic [3:0]  f_count;
    logic        f_full, f_empty, f_afull, f_aempty, f_ahalf, f_ovf, f_udf;

    adc_sync_fifo #(.DATA_W(14), .DEPTH(8), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(f_flush), .clr_err(f_clr_err),
        .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .almst_full_th(f_af_th), .almst_empty_th(f_ae_th),
        .fifo_count(f_count), .fifo_full(f_full), .fifo_empty(f_empty),
        .fifo_almst_full(f_afull), .fifo_almst_empty(f_aempty),
        .fifo_above_half(f_ahalf), .overflow(f_ovf), .underflow(f_udf)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // reference model of the standard instance
    logic [13:0] mq[$];
    logic [13:0] sb[$];
    logic [13:0] mlast = '0;
    bit          mov = 0, mun = 0;

    task automatic chk_flags();
        int n;
        n = mq.size();
        chk("count",      32'(fifo_count),       32'(n));
        chk("full",       32'(fifo_full),        32'(n == 64));
        chk("empty",      32'(fifo_empty),       32'(n == 0));
        chk("almst_full", 32'(fifo_almst_full),  32'(n >= 60));
        chk("almst_empty",32'(fifo_almst_empty), 32'(n <= 4));
        chk("above_half", 32'(fifo_above_half),  32'(n > 32));
        chk("overflow",   32'(overflow),         32'(mov));
        chk("underflow",  32'(underflow),        32'(mun));
    endtask

    task automatic cyc(input bit w, input logic [13:0] d, input bit r, input bit fl, input bit clr);
        bit wacc, racc, ovs, uns;
        logic [13:0] e;
        @(negedge clk);
        wr_en = w; wr_data = d; rd_en = r; flush = fl; clr_err = clr;
        wacc = w && !fl && mq.size() < 64;
        racc = r && !fl && mq.size() > 0;
        ovs  = w && !fl && mq.size() == 64;
        uns  = r && !fl && !racc;
        mov  = ovs || (mov && !clr);
        mun  = uns || (mun && !clr);
        if (racc) sb.push_back(mq.pop_front());
        if (wacc) mq.push_back(d);
        if (fl) mq.delete();
        @(posedge clk);
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(racc));
        if (racc) begin
            e = sb.pop_front();
            chk("rd_data", 32'(rd_data), 32'(e));
            mlast = e;
        end else begin
            chk("rd_hold", 32'(rd_data), 32'(mlast));
        end
        chk_flags();
        wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
    endtask

    task automatic model_reset();
        mq.delete(); sb.delete();
        mlast = '0; mov = 0; mun = 0;
    endtask

    task automatic chk_reset_state();
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data",  32'(rd_data),  0);
        chk_flags();
        chk("rst_f_valid",  32'(f_rd_valid), 0);
        chk("rst_f_count",  32'(f_count),    0);
    endtask

    task automatic fstep(input bit w, input logic [13:0] d, input bit r);
        @(negedge clk);
        f_wr_en = w; f_wr_data = d; f_rd_en = r;
        @(posedge clk);
        #1;
        f_wr_en = 0; f_rd_en = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [13:0] dcnt;
        bit w, r;

        // async reset
        #2 rst_n = 0;
        #1;
        model_reset();
        chk_reset_state();
        @(negedge clk); rst_n = 1;

        // FWFT: write into empty appears one edge later
        fstep(1, 14'h0123, 0);
        chk("f_lat_valid0", 32'(f_rd_valid), 0);
        chk("f_lat_count",  32'(f_count),    1);
        fstep(0, 0, 0);
        chk("f_valid1",     32'(f_rd_valid), 1);
        chk("f_data123",    32'(f_rd_data),  32'h123);
        fstep(1, 14'h0456, 0);
        chk("f_count2",     32'(f_count),    2);
        chk("f_still123",   32'(f_rd_data),  32'h123);
        fstep(0, 0, 1);
        chk("f_nobubble_v", 32'(f_rd_valid), 1);
        chk("f_data456",    32'(f_rd_data),  32'h456);
        chk("f_count1",     32'(f_count),    1);
        fstep(0, 0, 1);
        chk("f_drained_v",  32'(f_rd_valid), 0);
        chk("f_empty",      32'(f_empty),    1);
        chk("f_udf0",       32'(f_udf),      0);
        fstep(0, 0, 1);
        chk("f_udf1",       32'(f_udf),      1);
        // FWFT burst: back-to-back pops
        fstep(1, 14'h0A01, 0);
        fstep(1, 14'h0A02, 0);
        fstep(1, 14'h0A03, 0);
        fstep(0, 0, 0);
        chk("f_b_count3",   32'(f_count),    3);
        chk("f_b_head",     32'(f_rd_data),  32'hA01);
        fstep(0, 0, 1);
        chk("f_b_2",        32'(f_rd_data),  32'hA02);
        fstep(0, 0, 1);
        chk("f_b_3",        32'(f_rd_data),  32'hA03);
        chk("f_b_v3",       32'(f_rd_valid), 1);
        fstep(0, 0, 1);
        chk("f_b_end",      32'(f_rd_valid), 0);

        // standard: fill, overflow, drain, underflow
        for (int i = 1; i <= 64; i++) cyc(1, 14'(i), 0, 0, 0);
        cyc(1, 14'h1234, 0, 0, 0);
        for (int i = 0; i < 65; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);

        // full boundary with simultaneous wr/rd
        for (int i = 0; i < 64; i++) cyc(1, 14'(16'h100 + i), 0, 0, 0);
        cyc(1, 14'h3FFF, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 63; i++) cyc(0, 0, 1, 0, 0);

        // empty boundary with simultaneous wr/rd
        cyc(1, 14'h0AAA, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);

        // random interleave, pointer wrap, threshold crossings
        dcnt = 14'h0200;
        for (int i = 0; i < 150; i++) begin
            w = $urandom_range(99) < 85;
            r = $urandom_range(99) < 25;
            cyc(w, dcnt, r, 0, 0);
            if (w) dcnt++;
        end
        for (int i = 0; i < 110; i++) begin
            w = $urandom_range(99) < 15;
            r = $urandom_range(99) < 75;
            cyc(w, dcnt, r, 0, 0);
            if (w) dcnt++;
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1, dcnt, $urandom_range(99) < 30, 0, 0);
            dcnt++;
        end
        cyc(0, 0, 0, 1, 0);
        chk("flush_count", 32'(fifo_count), 0);
        chk("flush_empty", 32'(fifo_empty), 1);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1, dcnt, 0, 0, 0);
            dcnt++;
        end

        // reset mid-burst takes effect without a clock edge
        @(negedge clk);
        wr_en = 1; wr_data = dcnt; rd_en = 1;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        model_reset();
        chk_reset_state();
        wr_en = 0; rd_en = 0;
        @(negedge clk); rst_n = 1;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 14'h0777, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
